// File: rtl/tiny16_pkg.sv
// tiny16_pkg: definitions shared by the tiny16 DMA block and its bench.
//   dma_state_t  - copy engine control states
//   REGION_*     - bus region codes carried in address[15:14]
package tiny16_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    RD_SETUP  = 3'd2,
    RD_ACTIVE = 3'd3,
    WR_SETUP  = 3'd4,
    WR_ACTIVE = 3'd5,
    DONE      = 3'd6
  } dma_state_t;

  localparam logic [1:0] REGION_ROM  = 2'b00;
  localparam logic [1:0] REGION_PORT = 2'b10;
  localparam logic [1:0] REGION_RAM  = 2'b11;

endpackage

// File: rtl/tiny16_dma_if.sv
// tiny16_dma_if: tiny16 memory bus as seen by a second initiator.
//   bus_req/bus_grant - arbitration handshake
//   address, nrd, nwr - address and active-low strobes
//   data_out/data_in  - write data / read data from the responder mux
//   ready             - responder ready, stretches the active phase while low
// master: the DMA engine. slave: arbiter plus responders.
interface tiny16_dma_if #(
  parameter int ADDR_BITS = 16,
  parameter int DATA_BITS = 16
);
  logic                 bus_req;
  logic                 bus_grant;
  logic [ADDR_BITS-1:0] address;
  logic                 nrd;
  logic                 nwr;
  logic [DATA_BITS-1:0] data_out;
  logic [DATA_BITS-1:0] data_in;
  logic                 ready;

  modport master (
    output bus_req, address, nrd, nwr, data_out,
    input  bus_grant, data_in, ready
  );

  modport slave (
    input  bus_req, address, nrd, nwr, data_out,
    output bus_grant, data_in, ready
  );
endinterface

// File: rtl/tiny16_bus_cycle.sv
// tiny16_bus_cycle: SETUP/ACTIVE strobe sequencer for one bus cycle.
//   clk, reset  - clock, synchronous active-high reset
//   go          - launch a cycle; accepted when idle or while the current
//                 cycle completes (back-to-back cycles)
//   dir         - 0 = read (nrd), 1 = write (nwr), sampled with go
//   ready       - responder ready
//   nrd, nwr    - registered active-low strobes
//   cycle_done  - high in the final ACTIVE cycle (ready=1)
module tiny16_bus_cycle (
  input  logic clk,
  input  logic reset,
  input  logic go,
  input  logic dir,
  input  logic ready,
  output logic nrd,
  output logic nwr,
  output logic cycle_done
);

  localparam logic [1:0] PH_IDLE   = 2'd0;
  localparam logic [1:0] PH_SETUP  = 2'd1;
  localparam logic [1:0] PH_ACTIVE = 2'd2;

  logic [1:0] phase;
  logic       dir_q;

  assign cycle_done = (phase == PH_ACTIVE) && ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= PH_IDLE;
      dir_q <= 1'b0;
      nrd   <= 1'b1;
      nwr   <= 1'b1;
    end else begin
      case (phase)
        PH_IDLE: begin
          if (go) begin
            phase <= PH_SETUP;
            dir_q <= dir;
          end
        end
        PH_SETUP: begin
          // Strobe falls as the active cycle begins, giving negedge-latched
          // responders a full cycle of address/data setup.
          phase <= PH_ACTIVE;
          nrd   <= dir_q;
          nwr   <= !dir_q;
        end
        PH_ACTIVE: begin
          if (ready) begin
            nrd <= 1'b1;
            nwr <= 1'b1;
            if (go) begin
              phase <= PH_SETUP;
              dir_q <= dir;
            end else begin
              phase <= PH_IDLE;
            end
          end
        end
        default: phase <= PH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/tiny16_dma.sv
// tiny16_dma: single-channel memory-to-memory copy engine.
//   clk, reset          - clock, synchronous active-high reset
//   start               - one-cycle pulse, accepted only when idle
//   abort               - level, ends the transfer after the current word
//   src, dst, count     - transfer setup, sampled on accepted start
//   src_inc, dst_inc    - 1 = advance that pointer after each word
//   bus                 - tiny16 bus, master side
//   busy, done, irq     - status: in progress, sticky complete, completion pulse
//   aborted             - sticky, transfer ended early by abort
module tiny16_dma
  import tiny16_pkg::*;
#(
  parameter int ADDR_BITS  = 16,
  parameter int DATA_BITS  = 16,
  parameter int COUNT_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_BITS-1:0]  src,
  input  logic [ADDR_BITS-1:0]  dst,
  input  logic [COUNT_BITS-1:0] count,
  input  logic                  src_inc,
  input  logic                  dst_inc,
  tiny16_dma_if.master          bus,
  output logic                  busy,
  output logic                  done,
  output logic                  irq,
  output logic                  aborted
);

  dma_state_t            state, state_nx;
  logic [ADDR_BITS-1:0]  src_ptr, dst_ptr, src_adv, dst_adv;
  logic [COUNT_BITS-1:0] remaining, remaining_nx;
  logic                  last_word;
  logic                  cycle_go, cycle_dir, cycle_done;
  logic                  req_q;
  logic [ADDR_BITS-1:0]  addr_q;
  logic [DATA_BITS-1:0]  wdata_q;

  // Pointer step wraps modulo 2^ADDR_BITS by construction.
  function automatic logic [ADDR_BITS-1:0] advance(input logic [ADDR_BITS-1:0] ptr,
                                                   input logic inc);
    return inc ? ptr + ADDR_BITS'(1) : ptr;
  endfunction

  function automatic logic [COUNT_BITS-1:0] dec_sat(input logic [COUNT_BITS-1:0] c);
    return (c == '0) ? c : c - COUNT_BITS'(1);
  endfunction

  assign src_adv      = advance(src_ptr, src_inc);
  assign dst_adv      = advance(dst_ptr, dst_inc);
  assign remaining_nx = dec_sat(remaining);
  assign last_word    = (remaining_nx == '0);

  assign bus.bus_req  = req_q;
  assign bus.address  = addr_q;
  assign bus.data_out = wdata_q;

  tiny16_bus_cycle u_cycle (
    .clk        (clk),
    .reset      (reset),
    .go         (cycle_go),
    .dir        (cycle_dir),
    .ready      (bus.ready),
    .nrd        (bus.nrd),
    .nwr        (bus.nwr),
    .cycle_done (cycle_done)
  );

  // cycle_go launches the sequencer exactly on entry to a SETUP state, so the
  // sequencer phase always mirrors the SETUP/ACTIVE half of this FSM.
  always_comb begin
    state_nx  = state;
    cycle_go  = 1'b0;
    cycle_dir = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = (count == '0) ? DONE : REQ;
      end
      REQ: begin
        if (abort) begin
          state_nx = DONE;
        end else if (bus.bus_grant) begin
          state_nx = RD_SETUP;
          cycle_go = 1'b1;
        end
      end
      RD_SETUP: state_nx = RD_ACTIVE;
      RD_ACTIVE: begin
        if (cycle_done) begin
          state_nx  = WR_SETUP;
          cycle_go  = 1'b1;
          cycle_dir = 1'b1;
        end
      end
      WR_SETUP: state_nx = WR_ACTIVE;
      WR_ACTIVE: begin
        // abort is only honoured here, so a started word is always finished.
        if (cycle_done) begin
          if (last_word || abort) begin
            state_nx = DONE;
          end else begin
            state_nx = RD_SETUP;
            cycle_go = 1'b1;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      irq     <= 1'b0;
      aborted <= 1'b0;
    end else begin
      state <= state_nx;
      req_q <= (state_nx != IDLE) && (state_nx != DONE);
      irq   <= (state == DONE);

      if (state == IDLE && start) begin
        busy    <= 1'b1;
        done    <= 1'b0;
        aborted <= 1'b0;
      end
      if (state == DONE) begin
        busy <= 1'b0;
        done <= 1'b1;
      end

      if ((state == REQ && abort) ||
          (state == WR_ACTIVE && cycle_done && abort && !last_word))
        aborted <= 1'b1;

      // The source pointer advances on the same edge that re-enters RD_SETUP,
      // so the next read address uses the advanced value.
      if (state_nx == RD_SETUP)
        addr_q <= (state == WR_ACTIVE) ? src_adv : src_ptr;
      else if (state_nx == WR_SETUP)
        addr_q <= dst_ptr;

      // wdata_q doubles as the read-to-write hold register.
      if (state == RD_ACTIVE && cycle_done)
        wdata_q <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      src_ptr   <= src;
      dst_ptr   <= dst;
      remaining <= count;
    end else if (state == WR_ACTIVE && cycle_done) begin
      src_ptr   <= src_adv;
      dst_ptr   <= dst_adv;
      remaining <= remaining_nx;
    end
  end

endmodule

// File: tb/tb_tiny16_dma.sv
// tb_tiny16_dma: directed bench for tiny16_dma with a simple bus responder.
// Read data model: data_in = address ^ 16'hA500. Writes are logged when the
// write strobe is low with ready high; port-region writes drive a LED bit.
module tb_tiny16_dma;
  import tiny16_pkg::*;

  logic        clk;
  logic        reset, start, abort;
  logic [15:0] src_i, dst_i, count_i;
  logic        src_inc, dst_inc;
  logic        busy, done, irq, aborted;

  tiny16_dma_if #(.ADDR_BITS(16), .DATA_BITS(16)) bus ();

  tiny16_dma #(.ADDR_BITS(16), .DATA_BITS(16), .COUNT_BITS(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .src     (src_i),
    .dst     (dst_i),
    .count   (count_i),
    .src_inc (src_inc),
    .dst_inc (dst_inc),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .irq     (irq),
    .aborted (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.data_in = bus.address ^ 16'hA500;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          rel      = 0;
  int          irq_cnt  = 0;
  int          irq_rel  = 0;
  int          nrd_low  = 0;
  int          nwr_low  = 0;
  int          rd_cnt   = 0;
  int          both_low = 0;
  int          req_seen = 0;
  int          rom_rd   = 0;
  int          ram_wr   = 0;
  logic        led      = 1'b0;
  logic [15:0] rd_addr[$];
  logic [15:0] wr_addr[$];
  logic [15:0] wr_data[$];

  // rel counts cycles after the start edge: it reads k at the negedge of cycle k.
  always @(negedge clk) begin
    rel <= start ? 0 : rel + 1;
    if (irq) begin
      irq_cnt <= irq_cnt + 1;
      irq_rel <= rel;
    end
    if (!bus.nrd) nrd_low <= nrd_low + 1;
    if (!bus.nwr) nwr_low <= nwr_low + 1;
    if (!bus.nrd && !bus.nwr) both_low <= both_low + 1;
    if (bus.bus_req) req_seen <= req_seen + 1;
    if (!bus.nrd && bus.ready) begin
      rd_cnt <= rd_cnt + 1;
      rd_addr.push_back(bus.address);
      if (bus.address[15:14] == REGION_ROM) rom_rd <= rom_rd + 1;
    end
    if (!bus.nwr && bus.ready) begin
      wr_addr.push_back(bus.address);
      wr_data.push_back(bus.data_out);
      if (bus.address[15:14] == REGION_PORT) led <= bus.data_out[0];
      if (bus.address[15:14] == REGION_RAM) ram_wr <= ram_wr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns #1 after edge 0, i.e. in cycle 0 of the transfer.
  task automatic pulse_start(input logic [15:0] s, input logic [15:0] d,
                             input logic [15:0] c, input logic si, input logic di);
    src_i   = s;
    dst_i   = d;
    count_i = c;
    src_inc = si;
    dst_inc = di;
    start   = 1'b1;
    tick(1);
    start   = 1'b0;
  endtask

  task automatic wait_irq(input string tag, input int budget);
    int base;
    base = irq_cnt;
    for (int i = 0; i < budget && irq_cnt == base; i++) tick(1);
    check(tag, irq_cnt - base, 1);
    tick(2);
  endtask

  initial begin
    int wb, rb, nl, nw, rq, bl, rr, rw;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    src_i = '0; dst_i = '0; count_i = '0; src_inc = 1'b1; dst_inc = 1'b1;
    bus.bus_grant = 1'b1;
    bus.ready     = 1'b1;
    tick(3);
    check("rst_nrd", bus.nrd, 1);
    check("rst_nwr", bus.nwr, 1);
    check("rst_req", bus.bus_req, 0);
    check("rst_addr", bus.address, 0);
    check("rst_wdata", bus.data_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_irq", irq, 0);
    check("rst_aborted", aborted, 0);
    reset = 1'b0;
    tick(2);

    // Three ROM words into RAM.
    wb = wr_addr.size(); bl = both_low; rr = rom_rd; rw = ram_wr;
    pulse_start(16'h0010, 16'hC000, 16'd3, 1'b1, 1'b1);
    check("t1_busy_c0", busy, 1);
    check("t1_req_c0", bus.bus_req, 1);
    wait_irq("t1_irq_seen", 40);
    check("t1_irq_cycle", irq_rel, 14);
    check("t1_nwrites", wr_addr.size() - wb, 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t1_waddr%0d", i), wr_addr[wb+i], 16'hC000 + i);
      check($sformatf("t1_wdata%0d", i), wr_data[wb+i], 16'hA510 + i);
    end
    check("t1_rom_reads", rom_rd - rr, 3);
    check("t1_ram_writes", ram_wr - rw, 3);
    check("t1_done", done, 1);
    check("t1_busy_end", busy, 0);
    check("t1_irq_pulse", irq, 0);
    check("t1_no_overlap", both_low - bl, 0);

    // Zero-length transfer.
    rq = req_seen; nl = nrd_low; nw = nwr_low;
    pulse_start(16'h0010, 16'hC000, 16'd0, 1'b1, 1'b1);
    check("t2_done_clr", done, 0);
    wait_irq("t2_irq_seen", 10);
    check("t2_irq_cycle", irq_rel, 1);
    check("t2_no_req", req_seen - rq, 0);
    check("t2_nrd_high", nrd_low - nl, 0);
    check("t2_nwr_high", nwr_low - nw, 0);
    check("t2_done", done, 1);

    // Five ready=0 samples in the first read.
    bus.ready = 1'b0;
    nl = nrd_low; rb = rd_cnt; wb = wr_addr.size();
    pulse_start(16'h0040, 16'hC040, 16'd1, 1'b1, 1'b1);
    for (int i = 0; i < 20 && bus.nrd; i++) tick(1);
    check("t3_rd_active", bus.nrd, 0);
    tick(5);
    bus.ready = 1'b1;
    wait_irq("t3_irq_seen", 30);
    check("t3_nrd_cycles", nrd_low - nl, 6);
    check("t3_captures", rd_cnt - rb, 1);
    check("t3_nwrites", wr_addr.size() - wb, 1);
    check("t3_waddr", wr_addr[wb], 16'hC040);
    check("t3_wdata", wr_data[wb], 16'hA540);
    check("t3_irq_cycle", irq_rel, 11);

    // Fixed destination on the LED port.
    rb = rd_addr.size(); wb = wr_addr.size();
    pulse_start(16'h0020, 16'h8000, 16'd4, 1'b1, 1'b0);
    wait_irq("t4_irq_seen", 60);
    check("t4_nwrites", wr_addr.size() - wb, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_waddr%0d", i), wr_addr[wb+i], 16'h8000);
      check($sformatf("t4_wdata%0d", i), wr_data[wb+i], 16'hA520 + i);
      check($sformatf("t4_raddr%0d", i), rd_addr[rb+i], 16'h0020 + i);
    end
    check("t4_led", led, 1);
    check("t4_irq_cycle", irq_rel, 18);

    // Source pointer wrap, with an extra start while busy.
    rb = rd_addr.size(); wb = wr_addr.size();
    pulse_start(16'hFFFF, 16'hC080, 16'd2, 1'b1, 1'b1);
    for (int i = 0; i < 20 && wr_addr.size() == wb; i++) tick(1);
    pulse_start(16'h1234, 16'h4321, 16'd0, 1'b0, 1'b0);
    check("t5_busy_kept", busy, 1);
    wait_irq("t5_irq_seen", 30);
    check("t5_nreads", rd_addr.size() - rb, 2);
    check("t5_raddr0", rd_addr[rb], 16'hFFFF);
    check("t5_raddr1", rd_addr[rb+1], 16'h0000);
    check("t5_nwrites", wr_addr.size() - wb, 2);
    check("t5_waddr1", wr_addr[wb+1], 16'hC081);
    check("t5_wdata1", wr_data[wb+1], 16'hA500);

    // Abort raised during the second word's read.
    rb = rd_cnt; wb = wr_addr.size();
    pulse_start(16'h0100, 16'hC100, 16'd5, 1'b1, 1'b1);
    for (int i = 0; i < 40 && !(!bus.nrd && (rd_cnt - rb) >= 1); i++) tick(1);
    check("t6_in_word2", rd_cnt - rb, 1);
    abort = 1'b1;
    wait_irq("t6_irq_seen", 30);
    abort = 1'b0;
    check("t6_nwrites", wr_addr.size() - wb, 2);
    check("t6_waddr1", wr_addr[wb+1], 16'hC101);
    check("t6_wdata1", wr_data[wb+1], 16'hA401);
    check("t6_aborted", aborted, 1);
    check("t6_done", done, 1);
    check("t6_irq_cycle", irq_rel, 10);

    // Abort already high while requesting the bus.
    rb = rd_cnt; wb = wr_addr.size(); nl = nrd_low;
    abort = 1'b1;
    pulse_start(16'h0000, 16'hC000, 16'd3, 1'b1, 1'b1);
    wait_irq("t7_irq_seen", 10);
    abort = 1'b0;
    check("t7_no_reads", rd_cnt - rb, 0);
    check("t7_no_writes", wr_addr.size() - wb, 0);
    check("t7_nrd_high", nrd_low - nl, 0);
    check("t7_aborted", aborted, 1);
    check("t7_irq_cycle", irq_rel, 2);

    // Reset while the write strobe is low.
    wb = wr_addr.size();
    pulse_start(16'h0030, 16'hC030, 16'd2, 1'b1, 1'b1);
    check("t8_aborted_clr", aborted, 0);
    for (int i = 0; i < 20 && bus.nwr; i++) tick(1);
    check("t8_wr_active", bus.nwr, 0);
    bus.ready = 1'b0;
    reset     = 1'b1;
    tick(1);
    check("t8_nwr", bus.nwr, 1);
    check("t8_nrd", bus.nrd, 1);
    check("t8_req", bus.bus_req, 0);
    check("t8_addr", bus.address, 0);
    check("t8_wdata", bus.data_out, 0);
    check("t8_busy", busy, 0);
    check("t8_done", done, 0);
    check("t8_irq", irq, 0);
    check("t8_aborted", aborted, 0);
    reset     = 1'b0;
    bus.ready = 1'b1;
    rq = req_seen; nl = nrd_low;
    tick(10);
    check("t8_quiet_req", req_seen - rq, 0);
    check("t8_quiet_rd", nrd_low - nl, 0);
    check("t8_no_writes", wr_addr.size() - wb, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tiny16_dma.md
# tiny16_dma

Single-channel memory-to-memory copy engine acting as a second initiator on the tiny16 memory bus. The CPU loads source, destination and word count, then pulses `start`. The block requests the bus and performs alternating read/write cycles with the same strobe and `ready` protocol the memory and port responders already implement. It signals completion with a level flag and a one-cycle interrupt pulse.

## Interface
Parameters:
- `ADDR_BITS`, default 16: bus address width.
- `DATA_BITS`, default 16: bus data width.
- `COUNT_BITS`, default 16: transfer word-count width.

Ports:
- `clk`  in  1  system clock, all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; accepted only in IDLE.
- `abort`  in  1  level; terminates the transfer at the next safe point.
- `src`  in  ADDR_BITS  source start address, sampled on accepted `start`.
- `dst`  in  ADDR_BITS  destination start address, sampled on accepted `start`.
- `count`  in  COUNT_BITS  number of words, sampled on accepted `start`.
- `src_inc`, `dst_inc`  in  1 each  1 = increment the address after each word; 0 = fixed address (port access).
- `bus_req`  out  1  bus request to the arbiter.
- `bus_grant`  in  1  arbiter grant; the CPU is held off while it is high.
- `address`  out  ADDR_BITS  bus address.
- `nrd`  out  1  active-low read strobe.
- `nwr`  out  1  active-low write strobe.
- `data_out`  out  DATA_BITS  write data.
- `data_in`  in  DATA_BITS  read data from the responder mux.
- `ready`  in  1  responder ready; extends the active phase while low.
- `busy`  out  1  high from the cycle after an accepted `start` until DONE is exited.
- `done`  out  1  sticky; set in DONE, cleared by an accepted `start` or by `reset`.
- `irq`  out  1  one-cycle pulse in DONE.
- `aborted`  out  1  sticky; set when the transfer ended by `abort`, cleared by `start`.

## Operation
- All outputs are registered.
- Reset values: `bus_req`=0, `nrd`=1, `nwr`=1, `address`=0, `data_out`=0, `busy`=0, `done`=0, `irq`=0, `aborted`=0, state IDLE.

States and transitions:
- IDLE: on `start`, latch `src`, `dst` and `count`. If `count`=0, go to DONE; otherwise go to REQ.
- REQ: `bus_req`=1. Wait for `bus_grant`=1, then go to RD_SETUP.
- RD_SETUP: `address`=src pointer; strobes high. Next state is RD_ACTIVE.
- RD_ACTIVE: `nrd`=0. While `ready`=0, stay in RD_ACTIVE. At the edge where `ready`=1, capture `data_in` into the hold register and go to WR_SETUP.
- WR_SETUP: `address`=dst pointer; `data_out`=hold register; strobes high. Next state is WR_ACTIVE.
- WR_ACTIVE: `nwr`=0 until `ready`=1. Then decrement the remaining count and advance the pointers per `src_inc`/`dst_inc`. If the remaining count is 0 or `abort` is high, go to DONE; otherwise go to RD_SETUP.
- DONE: `bus_req`=0, `irq`=1, `done`=1. Next state is IDLE.

Rules and boundary conditions:
- Pointer arithmetic is modulo 2^ADDR_BITS: 0xFFFF+1 wraps to 0x0000.
- The remaining count never underflows.
- Strobes are never low in SETUP, REQ, DONE or IDLE. `nrd` and `nwr` are never low together.
- `abort`:
  - In REQ: go to DONE without any bus cycle.
  - During a read: the read and its paired write complete, then go to DONE. A word is never half-copied.
  - `aborted` is set only when words remained.
- `bus_grant` dropping mid-transfer is a protocol error. The arbiter guarantees grant is held while `bus_req`=1, so the block does not check it.
- `start` while `busy` is ignored; the latched registers are unchanged.
- `reset` mid-cycle: strobes high and `bus_req` low on the following edge. No further bus activity.

## Timing
- Accepted `start` at edge 0: `busy` and `bus_req` are high after edge 0.
- With `bus_grant` already high, the first RD_SETUP starts after edge 1.
- Each word takes 4 cycles at `ready`=1, plus one cycle per `ready`=0 sample in each active phase.
- Latency for N words, no wait states, grant immediate: `irq` is high in cycle 4N+2 after `start`. For `count`=0, `irq` is high in cycle 1.
- Strobes fall at the start of the active cycle, so the existing negedge-latched responders have a full cycle of data setup before capture.

## Structure
- Shared package `tiny16_pkg`: state enum `dma_state_t` (IDLE, REQ, RD_SETUP, RD_ACTIVE, WR_SETUP, WR_ACTIVE, DONE) and the bus-region constants (ROM 2'b00, PORT 2'b10, RAM 2'b11 in `address[15:14]`).
- One natural sub-module, `tiny16_bus_cycle`: the SETUP/ACTIVE strobe sequencer with `ready` wait. It is reused for read and write with a direction input and a `cycle_done` pulse.

## Test plan
- src=0x0010, dst=0xC000, count=3, both inc, `ready`=1, grant tied high: the three ROM words appear at 0xC000–0xC002, `irq` pulses in cycle 14, `done`=1.
- count=0: `irq` pulses in cycle 1, `nrd`/`nwr` stay high throughout, `bus_req` never asserts.
- `ready` held low for 5 cycles during the first RD_ACTIVE: `nrd` is low for exactly 6 cycles, one capture occurs, and the data written equals the data read.
- dst=0x8000, `dst_inc`=0, count=4: four writes to 0x8000, the LED follows bit 0 of each word, and `src` advances by 4.
- src=0xFFFF, count=2, `src_inc`=1: the second read address is 0x0000.
- Mid-transfer cases:
  - `abort` during word 2 of 5: the transfer ends after word 2's write and `aborted`=1.
  - A separate run with `reset` during WR_ACTIVE: `nwr`=1 and `bus_req`=0 on the next edge, and all outputs return to their reset values.
